// File: rtl/ushift_ctrl.sv
// ushift_ctrl: command sequencer driving an external 4-bit universal shift register; rotation enabled by USHIFT_CTRL_ROTATE_EN
module ushift_ctrl (
  input  logic       clk,
  input  logic       clear_b,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [1:0] cmd_cnt,
  input  logic [3:0] cmd_data,
  input  logic       cmd_fill,
  input  logic [3:0] a_par,
  output logic [1:0] sel,
  output logic       msb_in,
  output logic       lsb_in,
  output logic [3:0] i_par,
  output logic       busy,
  output logic       done
);
  localparam logic [1:0] IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2;
  localparam logic [2:0] NOP = 3'd0, LOAD = 3'd1, SHR = 3'd2, SHL = 3'd3, ROR = 3'd4, ROL = 3'd5, CLR = 3'd6, RSV = 3'd7;
`ifdef USHIFT_CTRL_ROTATE_EN
  localparam logic ROT = 1'b1;
`else
  localparam logic ROT = 1'b0;
`endif
  logic [1:0] state;
  logic [2:0] op;
  logic [2:0] cnt;
  logic [3:0] data;
  logic       fill;
  logic       hs;
  logic       exec;
  assign hs = cmd_valid & cmd_ready;
  assign exec = state == EXEC;
  // command capture, step countdown and IDLE -> EXEC -> DONE sequencing
  always_ff @(posedge clk or negedge clear_b) begin
    if (!clear_b) begin
      state <= IDLE;
      op <= NOP;
      cnt <= 3'd0;
      data <= 4'd0;
      fill <= 1'b0;
    end else if (hs) begin
      op <= cmd_op;
      data <= cmd_op == CLR ? 4'd0 : cmd_data;
      fill <= cmd_fill;
      cnt <= (cmd_op == LOAD || cmd_op == CLR) ? 3'd1 : {1'b0, cmd_cnt} + 3'd1;
      state <= (cmd_op == NOP || cmd_op == RSV) ? DONE : EXEC;
    end else if (exec) begin
      cnt <= cnt - 3'd1;
      state <= cnt == 3'd1 ? DONE : EXEC;
    end else if (state == DONE) begin
      state <= IDLE;
    end
  end
  // register mode and serial inputs; rotation feeds the opposite end of the register back in
  always_comb begin
    sel = !exec ? 2'b00 : (op == LOAD || op == CLR) ? 2'b11 : (op == SHR || op == ROR) ? 2'b01 : (op == SHL || op == ROL) ? 2'b10 : 2'b00;
    msb_in = (exec && ROT && op == ROR) ? a_par[0] : fill;
    lsb_in = (exec && ROT && op == ROL) ? a_par[3] : fill;
  end
  assign i_par = data;
  assign cmd_ready = state == IDLE;
  assign busy = state != IDLE;
  assign done = state == DONE;
endmodule

// File: tb/tb_ushift_ctrl.sv
// tb_ushift_ctrl: directed bench with a command-level model of ushift_ctrl and its shift register
module tb_ushift_ctrl;
  logic clk = 1'b0, clear_b = 1'b0, cmd_valid = 1'b0, cmd_fill = 1'b0;
  logic [2:0] cmd_op = 3'd0;
  logic [1:0] cmd_cnt = 2'd0;
  logic [3:0] cmd_data = 4'd0;
  logic cmd_ready, msb_in, lsb_in, busy, done;
  logic [1:0] sel;
  logic [3:0] i_par, areg;
  int nvec = 0, nerr = 0;
`ifdef USHIFT_CTRL_ROTATE_EN
  localparam logic [3:0] ROL_EXP = 4'b0011, ROR_EXP = 4'b1011;
`else
  localparam logic [3:0] ROL_EXP = 4'b0010, ROR_EXP = 4'b0000;
`endif
  ushift_ctrl dut (
    .clk(clk), .clear_b(clear_b), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_cnt(cmd_cnt), .cmd_data(cmd_data), .cmd_fill(cmd_fill),
    .a_par(areg), .sel(sel), .msb_in(msb_in), .lsb_in(lsb_in), .i_par(i_par),
    .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  // the controlled universal shift register, sharing clear_b
  always @(posedge clk or negedge clear_b)
    if (!clear_b) areg <= 4'd0;
    else if (sel == 2'b01) areg <= {msb_in, areg[3:1]};
    else if (sel == 2'b10) areg <= {areg[2:0], lsb_in};
    else if (sel == 2'b11) areg <= i_par;
  function automatic int steps(input logic [2:0] op, input logic [1:0] c);
    return (op == 3'd0 || op == 3'd7) ? 0 : (op == 3'd1 || op == 3'd6) ? 1 : int'(c) + 1;
  endfunction
  function automatic logic [1:0] mode(input logic [2:0] op);
    return (op == 3'd1 || op == 3'd6) ? 2'b11 : (op == 3'd2 || op == 3'd4) ? 2'b01 : (op == 3'd3 || op == 3'd5) ? 2'b10 : 2'b00;
  endfunction
  function automatic logic [3:0] apply(input logic [3:0] r, input logic [2:0] op, input logic [1:0] c, input logic [3:0] d, input logic f);
    logic [3:0] v;
    logic rot;
`ifdef USHIFT_CTRL_ROTATE_EN
    rot = 1'b1;
`else
    rot = 1'b0;
`endif
    v = r;
    if (op == 3'd1) v = d;
    else if (op == 3'd6) v = 4'd0;
    else if (op >= 3'd2 && op <= 3'd5)
      for (int i = 0; i <= int'(c); i++)
        if (op == 3'd2 || op == 3'd4) v = {(rot && op == 3'd4) ? v[0] : f, v[3:1]};
        else v = {v[2:0], (rot && op == 3'd5) ? v[3] : f};
    return v;
  endfunction
  int ph = 0, n = 0;
  logic [2:0] mop = 3'd0;
  logic [3:0] mdata = 4'd0, mreg = 4'd0;
  // model: ph counts cycles since acceptance; 1..n executing, n+1 done, 0 idle
  always @(posedge clk or negedge clear_b)
    if (!clear_b) begin
      ph <= 0; n <= 0; mop <= 3'd0; mdata <= 4'd0; mreg <= 4'd0;
    end else if (ph == 0) begin
      if (cmd_valid) begin
        mop <= cmd_op;
        mdata <= cmd_op == 3'd6 ? 4'd0 : cmd_data;
        n <= steps(cmd_op, cmd_cnt);
        mreg <= apply(mreg, cmd_op, cmd_cnt, cmd_data, cmd_fill);
        ph <= 1;
      end
    end else ph <= (ph == n + 1) ? 0 : ph + 1;
  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    chk("sel", 8'(sel), 8'((ph >= 1 && ph <= n) ? mode(mop) : 2'b00));
    chk("busy", 8'(busy), 8'(ph != 0));
    chk("done", 8'(done), 8'(ph != 0 && ph == n + 1));
    chk("cmd_ready", 8'(cmd_ready), 8'(ph == 0));
    chk("i_par", 8'(i_par), 8'(mdata));
    if (ph == 0 || ph == n + 1) chk("a_par", 8'(areg), 8'(mreg));
  end
  task automatic run(input logic [2:0] op, input logic [1:0] c, input logic [3:0] d, input logic f, input logic [3:0] ea, input int ecyc, input string nm);
    int dc, ec;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = op; cmd_cnt = c; cmd_data = d; cmd_fill = f;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_op = 3'($urandom); cmd_cnt = 2'($urandom); cmd_data = 4'($urandom); cmd_fill = 1'($urandom);
    dc = 0; ec = 0;
    repeat (7) @(negedge clk) begin
      dc += int'(done);
      ec += int'(sel != 2'b00);
    end
    chk({nm, " result"}, 8'(areg), 8'(ea));
    chk({nm, " done pulses"}, 8'(dc), 8'(1));
    chk({nm, " exec cycles"}, 8'(ec), 8'(ecyc));
  endtask
  initial begin
    int dc;
    repeat (2) @(posedge clk); #1 clear_b = 1'b1;
    @(negedge clk);
    chk("rst cmd_ready", 8'(cmd_ready), 8'(1));
    chk("rst sel", 8'(sel), 8'(0));
    chk("rst msb/lsb", 8'({msb_in, lsb_in}), 8'(0));
    chk("rst i_par", 8'(i_par), 8'(0));
    chk("rst busy/done", 8'({busy, done}), 8'(0));
    run(3'd1, 2'd0, 4'b1101, 1'b0, 4'b1101, 1, "load");
    run(3'd2, 2'd1, 4'b0000, 1'b1, 4'b1111, 2, "shr");
    run(3'd1, 2'd0, 4'b1001, 1'b0, 4'b1001, 1, "load2");
    run(3'd5, 2'd0, 4'b0000, 1'b0, ROL_EXP, 1, "rol");
    run(3'd1, 2'd0, 4'b1011, 1'b0, 4'b1011, 1, "load3");
    run(3'd4, 2'd3, 4'b0000, 1'b0, ROR_EXP, 4, "ror");
    run(3'd0, 2'd3, 4'b0110, 1'b1, ROR_EXP, 0, "nop");
    run(3'd7, 2'd2, 4'b0110, 1'b1, ROR_EXP, 0, "rsv");
    run(3'd1, 2'd0, 4'b0110, 1'b0, 4'b0110, 1, "load4");
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = 3'd3; cmd_cnt = 2'd2; cmd_fill = 1'b1;
    @(posedge clk); #1;
    cmd_op = 3'd6; cmd_data = 4'b1111;
    repeat (4) @(posedge clk); #1;
    chk("held shl result", 8'(areg), 8'(4'b0111));
    chk("held ready", 8'(cmd_ready), 8'(1));
    @(posedge clk); #1 cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("clr result", 8'(areg), 8'(0));
    run(3'd1, 2'd0, 4'b1010, 1'b0, 4'b1010, 1, "load5");
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = 3'd2; cmd_cnt = 2'd3; cmd_fill = 1'b0;
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(posedge clk); #3 clear_b = 1'b0;
    #1;
    chk("abort sel", 8'(sel), 8'(0));
    chk("abort busy", 8'(busy), 8'(0));
    chk("abort a_par", 8'(areg), 8'(0));
    chk("abort ready", 8'(cmd_ready), 8'(1));
    #3 clear_b = 1'b1;
    dc = 0;
    repeat (6) @(negedge clk) dc += int'(done);
    chk("abort no done", 8'(dc), 8'(0));
    run(3'd1, 2'd0, 4'b0101, 1'b0, 4'b0101, 1, "load6");
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/ushift_ctrl.md
USHIFT_CTRL -- requirements
Module: ushift_ctrl

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 clear_b  input  1  asynchronous active-low reset.
REQ-003 cmd_valid  input  1  command offered.
REQ-004 cmd_ready  output  1  controller can accept a command; high only in IDLE.
REQ-005 cmd_op  input  3  000 NOP, 001 LOAD, 010 SHR, 011 SHL, 100 ROR, 101 ROL, 110 CLR, 111 reserved (NOP).
REQ-006 cmd_cnt  input  2  shift/rotate count minus one (1..4 steps); ignored for NOP/LOAD/CLR.
REQ-007 cmd_data  input  4  parallel value for LOAD.
REQ-008 cmd_fill  input  1  serial fill bit for SHR/SHL.
REQ-009 a_par  input  4  current contents of the controlled 4-bit universal shift register.
REQ-010 sel  output  2  register mode: 00 hold, 01 shift right (msb_in into bit 3), 10 shift left (lsb_in into bit 0), 11 parallel load.
REQ-011 msb_in  output  1  serial input to register bit 3.
REQ-012 lsb_in  output  1  serial input to register bit 0.
REQ-013 i_par  output  4  parallel load value to register.
REQ-014 busy  output  1  high in EXEC and DONE.
REQ-015 done  output  1  one-cycle pulse when a command completes.

Function
REQ-016 States: IDLE, EXEC, DONE; handshake fires on a clk edge with cmd_valid & cmd_ready.
REQ-017 On handshake: capture op, step count (cmd_cnt+1, or 1 for LOAD/CLR), data (0 for CLR), fill; go to EXEC; NOP/reserved go directly to DONE.
REQ-018 EXEC lasts exactly the captured step count in cycles, then goes to DONE; DONE lasts one cycle, then IDLE.
REQ-019 sel = 00 in IDLE and DONE; in EXEC: LOAD/CLR 11, SHR/ROR 01, SHL/ROL 10.
REQ-020 msb_in: ROR in EXEC -> a_par[0] (combinational); otherwise captured fill; lsb_in: ROL in EXEC -> a_par[3]; otherwise captured fill.
REQ-021 i_par drives the captured data at all times (0 after reset).
REQ-022 Latency: handshake at edge k -> LOAD visible on a_par after edge k+1; N-step shift complete after edge k+N; done high in the following cycle; cmd_ready high again one cycle later.
REQ-023 cmd_valid while busy is ignored and not queued; command inputs may change freely outside the handshake edge.
REQ-024 Step counter decrements each EXEC cycle; no wrap beyond 4 steps; count 4 on ROR/ROL returns the original value.

Reset
REQ-025 clear_b low asynchronously forces IDLE, sel=00, msb_in=0, lsb_in=0, i_par=0, done=0, busy=0, cmd_ready=1 after release.
REQ-026 Reset mid-command aborts it with no done pulse; the shared register is cleared by the same clear_b.

Configuration
REQ-027 Macro USHIFT_CTRL_ROTATE_EN: defined -> ROR/ROL behave per REQ-019/020.
REQ-028 Not defined -> ROR/ROL execute as SHR/SHL with the captured fill bit; all other behaviour identical.

Verification
REQ-029 Reset, then LOAD 1101 -> sel=11 for one cycle, a_par=1101, done one cycle, cmd_ready returns.
REQ-030 a_par=1101, SHR cnt=1 fill=1 -> sel=01 two cycles, a_par=1111, single done pulse.
REQ-031 a_par=1001, ROL cnt=0 (macro on) -> a_par=0011; macro off, fill=0 -> a_par=0010.
REQ-032 a_par=1011, ROR cnt=3 (macro on) -> four sel=01 cycles, a_par=1011 restored.
REQ-033 Second cmd_valid held during a SHL cnt=2 -> ignored until IDLE, then accepted; CLR -> a_par=0000.
REQ-034 clear_b pulsed low in the second cycle of SHR cnt=3 -> immediate IDLE, a_par=0000, no done, sel=00.
